// File: rtl/red_pitaya_asg_pkg.sv
// ============================================================================
// Package : red_pitaya_asg_pkg
// State encodings shared by the double-buffered ASG scheduler.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package red_pitaya_asg_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_RUN_PEND = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    ARMED    = ST_ARMED,
    RUN      = ST_RUN,
    RUN_PEND = ST_RUN_PEND
  } asg_dbuf_state_t;

endpackage

`default_nettype wire

// File: rtl/red_pitaya_asg_dbuf_ctrl.sv
// ============================================================================
// Module : red_pitaya_asg_dbuf_ctrl
// Ping-pong half scheduler for one double-buffered ASG channel.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module red_pitaya_asg_dbuf_ctrl
  import red_pitaya_asg_pkg::*;
#(
  parameter int RSZ           = 14,
  parameter int CNT_W         = 16,
  parameter bit UNDERRUN_STOP = 1'b0
) (
  input  logic             dac_clk_i,
  input  logic             dac_rst_i,
  input  logic             cfg_en_i,
  input  logic             cfg_clr_i,
  input  logic             commit_i,
  input  logic             trig_i,
  input  logic             buf_done_i,
  output logic             run_o,
  output logic             start_o,
  output logic [RSZ:0]     rd_base_o,
  output logic [RSZ:0]     wr_base_o,
  output logic             wr_free_o,
  output logic             irq_o,
  output logic             underrun_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] swap_cnt_o,
  output logic [CNT_W-1:0] urun_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  asg_dbuf_state_t r_state;
  asg_dbuf_state_t w_state_nxt;
  logic            r_rd_sel;
  logic            w_rd_sel_nxt;
  logic            r_pend;
  logic            w_pend_nxt;
  logic            r_trig_q;
  logic            w_trig_edge;
  logic            w_start;
  logic            w_swap;
  logic            w_urun;
  logic            w_ovr;
  logic [RSZ:0]    w_wr_base_nxt;
  logic            w_run_nxt;

  assign w_trig_edge = trig_i & ~r_trig_q;
  assign state_o     = r_state;

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_pend only carries a pending half while ARMED; in RUN_PEND the state itself holds it.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_sel_nxt = r_rd_sel;
    w_pend_nxt   = r_pend;
    w_start      = 1'b0;
    w_swap       = 1'b0;
    w_urun       = 1'b0;
    w_ovr        = 1'b0;
    if (!cfg_en_i) begin
      w_state_nxt  = IDLE;
      w_rd_sel_nxt = 1'b0;
      w_pend_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_pend_nxt = 1'b0;
          if (commit_i) begin
            w_state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (commit_i) begin
            w_ovr      = r_pend;
            w_pend_nxt = 1'b1;
          end
          if (w_trig_edge) begin
            w_state_nxt = (r_pend | commit_i) ? RUN_PEND : RUN;
            w_pend_nxt  = 1'b0;
            w_start     = 1'b1;
          end
        end
        RUN: begin
          if (buf_done_i && commit_i) begin
            w_swap = 1'b1;
          end else if (buf_done_i) begin
            w_urun = 1'b1;
            if (UNDERRUN_STOP) begin
              w_state_nxt = ARMED;
            end else begin
              w_start = 1'b1;
            end
          end else if (commit_i) begin
            w_state_nxt = RUN_PEND;
          end
        end
        RUN_PEND: begin
          if (buf_done_i) begin
            w_swap      = 1'b1;
            w_state_nxt = commit_i ? RUN_PEND : RUN;
          end else if (commit_i) begin
            w_ovr = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
      if (w_swap) begin
        w_rd_sel_nxt = ~r_rd_sel;
        w_start      = 1'b1;
      end
    end
  end

  assign w_run_nxt     = (w_state_nxt == RUN) || (w_state_nxt == RUN_PEND);
  // IDLE exposes half 0 for the very first fill even though rd_sel is also 0.
  assign w_wr_base_nxt = (w_state_nxt == IDLE) ? '0 : {~w_rd_sel_nxt, {RSZ{1'b0}}};

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      r_rd_sel   <= 1'b0;
      r_pend     <= 1'b0;
      r_trig_q   <= 1'b0;
      run_o      <= 1'b0;
      start_o    <= 1'b0;
      irq_o      <= 1'b0;
      rd_base_o  <= '0;
      wr_base_o  <= '0;
      wr_free_o  <= 1'b1;
      underrun_o <= 1'b0;
      overrun_o  <= 1'b0;
      swap_cnt_o <= '0;
      urun_cnt_o <= '0;
    end else begin
      r_rd_sel  <= w_rd_sel_nxt;
      r_pend    <= w_pend_nxt;
      r_trig_q  <= trig_i;
      run_o     <= w_run_nxt;
      start_o   <= w_start;
      irq_o     <= w_swap;
      rd_base_o <= {w_rd_sel_nxt, {RSZ{1'b0}}};
      wr_base_o <= w_wr_base_nxt;
      wr_free_o <= !(w_pend_nxt || (w_state_nxt == RUN_PEND));
      if (cfg_clr_i) begin
        underrun_o <= 1'b0;
        overrun_o  <= 1'b0;
        swap_cnt_o <= '0;
        urun_cnt_o <= '0;
      end else begin
        if (w_urun) begin
          underrun_o <= 1'b1;
        end
        if (w_ovr) begin
          overrun_o <= 1'b1;
        end
        if (w_swap && (swap_cnt_o != c_cnt_max)) begin
          swap_cnt_o <= swap_cnt_o + c_cnt_one;
        end
        if (w_urun && (urun_cnt_o != c_cnt_max)) begin
          urun_cnt_o <= urun_cnt_o + c_cnt_one;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_red_pitaya_asg_dbuf_ctrl.sv
// ============================================================================
// Module : tb_red_pitaya_asg_dbuf_ctrl
// Scoreboard bench: replay (dut0) and stop-on-underrun (dut1) variants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_red_pitaya_asg_dbuf_ctrl;

  localparam int RSZ   = 14;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  typedef struct packed {
    logic          run;
    logic          start;
    logic [RSZ:0]  rd_base;
    logic [RSZ:0]  wr_base;
    logic          wr_free;
    logic          irq;
    logic          urun;
    logic          ovr;
    logic [CNT_W-1:0] swap_cnt;
    logic [CNT_W-1:0] urun_cnt;
    logic [1:0]    state;
  } out_t;

  logic clk = 1'b0;
  logic rst, en, clr, commit, trig, done;

  logic run0, start0, free0, irq0, ur0, ov0;
  logic run1, start1, free1, irq1, ur1, ov1;
  logic [RSZ:0] rd0, wr0, rd1, wr1;
  logic [CNT_W-1:0] sc0, uc0, sc1, uc1;
  logic [1:0] st0, st1;
  out_t act0, act1;

  always #4 clk = ~clk;

  red_pitaya_asg_dbuf_ctrl #(.RSZ(RSZ), .CNT_W(CNT_W), .UNDERRUN_STOP(1'b0)) u_dut0 (
    .dac_clk_i(clk), .dac_rst_i(rst), .cfg_en_i(en), .cfg_clr_i(clr),
    .commit_i(commit), .trig_i(trig), .buf_done_i(done),
    .run_o(run0), .start_o(start0), .rd_base_o(rd0), .wr_base_o(wr0),
    .wr_free_o(free0), .irq_o(irq0), .underrun_o(ur0), .overrun_o(ov0),
    .swap_cnt_o(sc0), .urun_cnt_o(uc0), .state_o(st0)
  );

  red_pitaya_asg_dbuf_ctrl #(.RSZ(RSZ), .CNT_W(CNT_W), .UNDERRUN_STOP(1'b1)) u_dut1 (
    .dac_clk_i(clk), .dac_rst_i(rst), .cfg_en_i(en), .cfg_clr_i(clr),
    .commit_i(commit), .trig_i(trig), .buf_done_i(done),
    .run_o(run1), .start_o(start1), .rd_base_o(rd1), .wr_base_o(wr1),
    .wr_free_o(free1), .irq_o(irq1), .underrun_o(ur1), .overrun_o(ov1),
    .swap_cnt_o(sc1), .urun_cnt_o(uc1), .state_o(st1)
  );

  assign act0 = {run0, start0, rd0, wr0, free0, irq0, ur0, ov0, sc0, uc0, st0};
  assign act1 = {run1, start1, rd1, wr1, free1, irq1, ur1, ov1, sc1, uc1, st1};

  // Reference model: mode 0=idle, 1=armed, 2=playing; pend = a filled half waits.
  int   m_mode [2];
  bit   m_pend [2];
  bit   m_half [2];
  bit   m_ur   [2];
  bit   m_ov   [2];
  int   m_sc   [2];
  int   m_uc   [2];
  bit   m_trig_q;

  int   checks   = 0;
  int   failures = 0;
  out_t q0 [$];
  out_t q1 [$];

  task automatic chk(input string name, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, a, e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_pend[d] = 0; m_half[d] = 0;
      m_ur[d] = 0; m_ov[d] = 0; m_sc[d] = 0; m_uc[d] = 0;
    end
    m_trig_q = 0;
  endtask

  task automatic model_step(input int d, input bit e, input bit c, input bit cm,
                            input bit te, input bit dn, output out_t o);
    bit st = 0, swap = 0, ur = 0, ov = 0;
    if (!e) begin
      m_mode[d] = 0; m_half[d] = 0; m_pend[d] = 0;
    end else begin
      case (m_mode[d])
        0: if (cm) m_mode[d] = 1;
        1: begin
          if (cm) begin
            if (m_pend[d]) ov = 1;
            m_pend[d] = 1;
          end
          if (te) begin
            m_mode[d] = 2;
            st = 1;
          end
        end
        2: begin
          if (dn) begin
            if (m_pend[d] || cm) begin
              swap = 1;
              m_half[d] = !m_half[d];
              m_pend[d] = m_pend[d] && cm;
            end else begin
              ur = 1;
              if (d == 1) m_mode[d] = 1;
              else st = 1;
            end
          end else if (cm) begin
            if (m_pend[d]) ov = 1;
            m_pend[d] = 1;
          end
        end
        default: ;
      endcase
    end
    if (c) begin
      m_ur[d] = 0; m_ov[d] = 0; m_sc[d] = 0; m_uc[d] = 0;
    end else begin
      if (ur) m_ur[d] = 1;
      if (ov) m_ov[d] = 1;
      if (swap && m_sc[d] < CMAX) m_sc[d]++;
      if (ur && m_uc[d] < CMAX) m_uc[d]++;
    end
    o.run      = (m_mode[d] == 2);
    o.start    = st | swap;
    o.irq      = swap;
    o.rd_base  = m_half[d] ? (RSZ+1)'(1 << RSZ) : '0;
    o.wr_base  = (m_mode[d] == 0) ? '0 : (m_half[d] ? '0 : (RSZ+1)'(1 << RSZ));
    o.wr_free  = !m_pend[d];
    o.urun     = m_ur[d];
    o.ovr      = m_ov[d];
    o.swap_cnt = CNT_W'(m_sc[d]);
    o.urun_cnt = CNT_W'(m_uc[d]);
    o.state    = (m_mode[d] == 0) ? 2'd0 : (m_mode[d] == 1) ? 2'd1 : (m_pend[d] ? 2'd3 : 2'd2);
  endtask

  // Called at a falling edge: drive one cycle of inputs and queue expected results.
  task automatic cycle(input bit e, input bit c, input bit cm, input bit t, input bit dn);
    out_t o0, o1;
    bit   te;
    en = e; clr = c; commit = cm; trig = t; done = dn;
    te = t & !m_trig_q;
    m_trig_q = t;
    model_step(0, e, c, cm, te, dn, o0);
    model_step(1, e, c, cm, te, dn, o1);
    q0.push_back(o0);
    q1.push_back(o1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    out_t r;
    rst = 1; en = 1; clr = 0; commit = 0; trig = 0; done = 0;
    #1;
    r = '0;
    r.wr_free = 1'b1;
    chk("reset_dut0", act0, r);
    chk("reset_dut1", act1, r);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) chk("cycle_dut0", act0, q0.pop_front());
      if (q1.size() > 0) chk("cycle_dut1", act1, q1.pop_front());
    end
  end

  initial begin
    bit tr;
    rst = 1; en = 1; clr = 0; commit = 0; trig = 0; done = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    cycle(1, 0, 1, 0, 0);
    repeat (18) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 1, 1, 1);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    do_reset();

    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 1, 1, 0);
      cycle(1, 0, 0, 1, 1);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 0, 1, 0);
    end
    cycle(1, 1, 1, 1, 1);

    tr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        tr = 0;
        do_reset();
      end else begin
        if ($urandom_range(0, 99) < 10) tr = !tr;
        cycle($urandom_range(0, 99) >= 1,
              $urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < 20,
              tr,
              $urandom_range(0, 99) < 15);
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d,%0d expected=0,0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/red_pitaya_asg_dbuf_ctrl.md
Name: red_pitaya_asg_dbuf_ctrl

Overview:
Ping-pong scheduler for one channel of the double-buffered arbitrary signal generator.
- The waveform table is split into two halves of 2**RSZ samples; the block tracks which half plays and which half software may refill.
- It arms playback and starts it on trigger, swaps halves at end-of-buffer, and flags underruns and overruns.
- It sits between the system-bus register bank (commit/clear strobes, status readback) and the ASG read-pointer datapath (start, base offsets, run enable).

Parameters:
RSZ, 14, log2 of samples per buffer half; full table is 2**(RSZ+1)
CNT_W, 16, width of the swap and underrun counters (saturating)
UNDERRUN_STOP, 0, 1 = stop and re-arm on underrun; 0 = replay the active half

Ports:
dac_clk_i  in  1  DAC clock, 125 MHz
dac_rst_i  in  1  asynchronous reset, active-high
cfg_en_i  in  1  channel enable; low forces IDLE synchronously
cfg_clr_i  in  1  pulse; clears sticky flags and counters
commit_i  in  1  pulse from software: the write half is filled
trig_i  in  1  trigger level; rising edge detected internally
buf_done_i  in  1  pulse from datapath: active half fully played
run_o  out  1  datapath enable
start_o  out  1  one-cycle pulse; datapath reloads its pointer from rd_base_o
rd_base_o  out  RSZ+1  base of the playing half, {rd_sel,RSZ'b0}
wr_base_o  out  RSZ+1  base of the writable half, {~rd_sel,RSZ'b0}
wr_free_o  out  1  write half may be filled (no commit pending)
irq_o  out  1  one-cycle pulse on every swap
underrun_o  out  1  sticky: buf_done_i arrived with no pending half
overrun_o  out  1  sticky: commit_i arrived while a half was already pending
swap_cnt_o  out  CNT_W  completed swaps, saturating
urun_cnt_o  out  CNT_W  underrun events, saturating
state_o  out  2  current state encoding

Behaviour:
- Reset values: all outputs 0; rd_sel=0; state=IDLE; trig_q=0; wr_free_o=1.
- Register rule: every output is registered and changes on the clock edge that samples its cause.
- Trigger edge: trig_edge = trig_i & ~trig_q, where trig_q is trig_i registered.

States (state_o encoding):
- IDLE (0): run_o=0, wr_base_o=0, wr_free_o=1.
  - commit_i -> ARMED. rd_sel stays 0, so half 0 becomes active and wr_base points to half 1.
- ARMED (1): run_o=0.
  - trig_edge -> RUN, with start_o=1 and run_o=1 on the same edge.
  - commit_i -> ARMED_PEND is not provided: commit in ARMED sets pending (PEND flag) and stays ARMED. On trig_edge, go to RUN_PEND instead of RUN.
- RUN (2): run_o=1, wr_free_o=1.
  - commit_i -> RUN_PEND, wr_free_o=0.
  - buf_done_i -> underrun:
    - always: underrun_o=1 and urun_cnt+1.
    - UNDERRUN_STOP=0: stay RUN, start_o pulse (replay the same half).
    - UNDERRUN_STOP=1: go to ARMED, run_o=0 on the next cycle.
  - commit_i and buf_done_i in the same cycle: treated as RUN_PEND + done, i.e. a swap with no underrun.
- RUN_PEND (3): run_o=1, wr_free_o=0.
  - buf_done_i -> RUN: rd_sel toggles, start_o=1, irq_o=1, swap_cnt+1, wr_free_o=1.
  - commit_i with no buf_done_i: overrun_o=1, state unchanged.
  - commit_i together with buf_done_i: the swap happens and the commit is counted as a new pending half, so the block stays in RUN_PEND with no overrun.
- trig_edge outside ARMED is ignored.

Priority and boundary rules:
- cfg_en_i=0 takes priority over all events: next state IDLE, rd_sel=0, run_o=0, pending cleared. Counters and sticky flags are kept.
- cfg_clr_i clears underrun_o, overrun_o and both counters. It wins over a same-cycle increment, so the result is 0.
- Counters saturate at 2**CNT_W-1.
- Async reset mid-playback drops run_o immediately and returns to the reset values.

Latency:
- Event to output: 1 clock.
- buf_done_i to first sample of the new half: the datapath's latency after start_o.

Decomposition:
- Package red_pitaya_asg_pkg: state enum asg_dbuf_state_t {IDLE, ARMED, RUN, RUN_PEND} (2 bits) and localparam encodings.
- No sub-module; the saturating counter is inline logic.

Test Plan:
1. Reset, then commit_i, then trig_i rises at cycle 20. Required: state ARMED after the commit; at cycle 21 start_o=1, run_o=1, rd_base_o=0, wr_base_o=2**14.
2. In RUN, commit_i then buf_done_i. Required: rd_base_o=2**14, irq_o=1 for one cycle, swap_cnt_o=1, wr_free_o=1, wr_base_o=0.
3. In RUN, buf_done_i with no commit, UNDERRUN_STOP=0. Required: start_o pulse, underrun_o=1, urun_cnt_o=1, rd_base_o unchanged. Repeat with UNDERRUN_STOP=1: state ARMED, run_o=0.
4. Two commit_i pulses while in RUN. Required: overrun_o=1, state RUN_PEND. Then cfg_clr_i: flags and counters read 0.
5. commit_i and buf_done_i in the same cycle from RUN. Required: swap, no underrun. From RUN_PEND, the same stimulus gives a swap and the state stays RUN_PEND.
6. cfg_en_i low mid-RUN, and separately an async dac_rst_i pulse. Required: run_o=0 next cycle or immediately respectively, rd_base_o=0; counters kept on disable and zeroed on reset.
